// File: rtl/display_pkg.sv
// Shared definitions for the dual-digit display multiplexer.
//   mux_state_t : scheduler states, visited BLANK_L -> DRIVE_L -> BLANK_R -> DRIVE_R
//   SEG_OFF     : active-low segment pattern with every segment dark
//   GLYPHS      : active-low hex glyphs 0-F, bit order {g,f,e,d,c,b,a}
package display_pkg;

    typedef enum logic [1:0] {
        BLANK_L = 2'd0,
        DRIVE_L = 2'd1,
        BLANK_R = 2'd2,
        DRIVE_R = 2'd3
    } mux_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // b and d are the lowercase glyphs so they stay distinct from 8 and 0.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic logic is_blank(input mux_state_t s);
        return (s == BLANK_L) || (s == BLANK_R);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex to seven-segment glyph lookup, purely combinational.
//   i_hex : 4-bit hex digit
//   o_seg : active-low segments {g,f,e,d,c,b,a}
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPHS[i_hex];

endmodule

// File: rtl/display_mux_scheduler.sv
// Time-multiplexing scheduler for the shared seven-segment bus. Alternates the
// bus between the left and right digits, inserting an all-off blanking interval
// before every visit, and snapshots both digits and the mask once per frame.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   digit_left   : hex value for the left digit
//   digit_right  : hex value for the right digit
//   blank_mask   : bit1 darkens the left visit, bit0 the right visit
//   seg_out      : shared segment bus, active-low {g,f,e,d,c,b,a}
//   toggle_left  : left digit enable, active-low
//   toggle_right : right digit enable, active-low
//   frame_done   : one-cycle pulse on the last DRIVE_R cycle
module display_mux_scheduler
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_left,
    input  logic [3:0] digit_right,
    input  logic [1:0] blank_mask,
    output logic [6:0] seg_out,
    output logic       toggle_left,
    output logic       toggle_right,
    output logic       frame_done
);

    localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

    // With blanking disabled the frame (and the snapshot) begins at DRIVE_L.
    localparam mux_state_t FRAME_START = HAS_BLANK ? BLANK_L : DRIVE_L;

    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("display_mux_scheduler: DWELL_CYCLES must be >= 1");
    end
    if (BLANK_CYCLES < 0) begin : g_bad_blank
        $error("display_mux_scheduler: BLANK_CYCLES must be >= 0");
    end

    mux_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    // Low from reset until the first edge after release, which performs the
    // initial frame-start entry and takes the first snapshot.
    logic             r_started;
    logic [3:0]       r_snap_left;
    logic [3:0]       r_snap_right;
    logic [1:0]       r_snap_mask;

    mux_state_t       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_load;
    logic             w_capture;
    logic [3:0]       w_left;
    logic [3:0]       w_right;
    logic [1:0]       w_mask;
    logic [3:0]       w_dec_in;
    logic [6:0]       w_glyph;
    logic [6:0]       w_seg_nxt;
    logic             w_tl_nxt;
    logic             w_tr_nxt;
    logic             w_fd_nxt;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        if (!r_started) begin
            w_next_state = FRAME_START;
            w_load       = 1'b1;
            w_capture    = 1'b1;
        end else if (r_cnt != '0) begin
            w_next_cnt = r_cnt - CNT_W'(1);
        end else begin
            w_load = 1'b1;
            unique case (r_state)
                BLANK_L: w_next_state = DRIVE_L;
                DRIVE_L: w_next_state = HAS_BLANK ? BLANK_R : DRIVE_R;
                BLANK_R: w_next_state = DRIVE_R;
                DRIVE_R: w_next_state = FRAME_START;
            endcase
            w_capture = (w_next_state == FRAME_START);
        end
        if (w_load) begin
            w_next_cnt = is_blank(w_next_state) ? BLANK_LOAD : DWELL_LOAD;
        end
    end

    // The registered outputs describe the state being entered, so the snapshot
    // taken on this edge must already be visible (matters when DRIVE_L opens
    // the frame with blanking disabled).
    assign w_left   = w_capture ? digit_left  : r_snap_left;
    assign w_right  = w_capture ? digit_right : r_snap_right;
    assign w_mask   = w_capture ? blank_mask  : r_snap_mask;
    assign w_dec_in = (w_next_state == DRIVE_R) ? w_right : w_left;

    seg_decoder u_seg_decoder (
        .i_hex (w_dec_in),
        .o_seg (w_glyph)
    );

    always_comb begin
        w_seg_nxt = SEG_OFF;
        w_tl_nxt  = 1'b1;
        w_tr_nxt  = 1'b1;
        unique case (w_next_state)
            DRIVE_L: begin
                if (!w_mask[1]) begin
                    w_seg_nxt = w_glyph;
                    w_tl_nxt  = 1'b0;
                end
            end
            DRIVE_R: begin
                if (!w_mask[0]) begin
                    w_seg_nxt = w_glyph;
                    w_tr_nxt  = 1'b0;
                end
            end
            BLANK_L, BLANK_R: begin
            end
        endcase
        w_fd_nxt = (w_next_state == DRIVE_R) && (w_next_cnt == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= BLANK_L;
            r_cnt        <= BLANK_LOAD;
            r_started    <= 1'b0;
            r_snap_left  <= 4'h0;
            r_snap_right <= 4'h0;
            r_snap_mask  <= 2'b11;
            seg_out      <= SEG_OFF;
            toggle_left  <= 1'b1;
            toggle_right <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_started    <= 1'b1;
            r_snap_left  <= w_left;
            r_snap_right <= w_right;
            r_snap_mask  <= w_mask;
            seg_out      <= w_seg_nxt;
            toggle_left  <= w_tl_nxt;
            toggle_right <= w_tr_nxt;
            frame_done   <= w_fd_nxt;
        end
    end

endmodule

// File: doc/display_mux_scheduler.md
# display_mux_scheduler

Time-multiplexing scheduler for the shared seven-segment bus on the dual-digit display. It owns the bus and alternates it between the left and right digits. Each handover is separated by a programmable all-off blanking interval to suppress ghosting. Each frame starts with a coherent snapshot of both hex inputs, so a display never tears mid-frame. It sits between the switch/data logic and the board pins, and replaces ad-hoc toggle-based muxing.

## Interface
- DWELL_CYCLES, 24000: clk cycles a digit is driven per visit (1 ms at 24 MHz); must be ≥1.
- BLANK_CYCLES, 240: clk cycles with all outputs off before each digit visit; 0 is legal and means no blanking.
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-low reset.
- digit_left  input  4  hex value for the left digit.
- digit_right  input  4  hex value for the right digit.
- blank_mask  input  2  per-digit suppress: bit1 is left, bit0 is right; 1 keeps that digit dark during its visit.
- seg_out  output  7  shared segment bus, active-low, bit order {g,f,e,d,c,b,a}.
- toggle_left  output  1  left digit enable, active-low (PNP driver).
- toggle_right  output  1  right digit enable, active-low.
- frame_done  output  1  one-cycle pulse on the last DWELL cycle of the right digit.

## Operation
- States: BLANK_L, DRIVE_L, BLANK_R, DRIVE_R, visited in that cyclic order.
- One down-counter, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1), is shared by all states.
  - It is loaded with N−1 on entry to a state of length N.
  - The state advances when the counter reads 0.
- BLANK_CYCLES=0: BLANK_L and BLANK_R are skipped entirely. DRIVE_R transitions directly to DRIVE_L, and DRIVE_L directly to DRIVE_R.
- Snapshot: digit_left, digit_right and blank_mask are captured into internal registers on the edge that enters BLANK_L (DRIVE_L when blanking is disabled). Input changes at any other time have no effect until the next frame.
- In a BLANK state: seg_out=7'h7F, toggle_left=1, toggle_right=1.
- In DRIVE_L: seg_out = decode(snapshot left); toggle_left=0 unless the snapshot left mask bit=1, in which case seg_out=7'h7F and toggle_left=1. toggle_right=1.
- DRIVE_R mirrors DRIVE_L for the right digit.
- Decode covers 0–F; A,b,C,d,E,F use the conventional glyphs (b and d lowercase).
- The two enables are never both 0 in any cycle.
- Reset (asynchronous assert):
  - State is BLANK_L with the counter loaded to BLANK_CYCLES−1.
  - Snapshot registers = 0, mask = 2'b11.
  - seg_out=7'h7F, both toggles=1, frame_done=0.
  - This applies immediately, including mid-visit.
- Release: the first snapshot occurs on the first edge that enters BLANK_L after reset deasserts. Until then the display stays dark.

## Timing
- All outputs are registered and update on the same clk edge as the state transition (registered Moore). No combinational path runs from inputs to outputs.
- Digit visit period = BLANK_CYCLES + DWELL_CYCLES. Frame period = 2 × (BLANK_CYCLES + DWELL_CYCLES).
- Latency from an input change to display: at most one frame plus BLANK_CYCLES cycles.
- frame_done is high in exactly one cycle per frame, coincident with the final DRIVE_R cycle. The BLANK_L entry (snapshot) occurs on the next edge.

## Structure
- Shared package display_pkg holds:
  - the state enum typedef (mux_state_t);
  - SEG_OFF = 7'h7F;
  - the 16-entry active-low glyph constant array.
- Sub-module seg_decoder (4-bit hex in, 7-bit active-low out, combinational) is instantiated once. Its input is muxed from the snapshot registers by current state; its output is registered into seg_out.
- Parameter checks are elaboration-time assertions: DWELL_CYCLES ≥ 1, BLANK_CYCLES ≥ 0.

## Test plan
All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2 unless noted.
- Reset then release, left=3, right=A, mask=0:
  - cycles 0–1 dark;
  - cycles 2–5 seg_out=7'h30 with toggle_left=0;
  - cycles 6–7 dark;
  - cycles 8–11 seg_out=7'h08 with toggle_right=0;
  - frame_done high in cycle 11 only; the pattern repeats with period 12.
- Change left from 3 to 7 during DRIVE_L: the current frame still shows 3; the next frame's DRIVE_L shows 7'h78.
- mask=2'b10, left=8, right=1: the left visit stays dark with toggle_left=1; the right visit shows 7'h79. The frame period is unchanged at 12.
- BLANK_CYCLES=0: DRIVE_L and DRIVE_R alternate every 4 cycles with no dark cycle. The enables are never both 0 in the same cycle. frame_done recurs every 8 cycles.
- Assert reset in the middle of DRIVE_R: in the same cycle (asynchronously) seg_out=7'h7F, both toggles=1 and frame_done=0. After release, the sequence restarts at BLANK_L.
- Sweep left over 0–F across 16 frames: seg_out in DRIVE_L matches the package glyph table for every value.
